// File: rtl/wb_stage_if.sv
// Bus bundle for wb_stage: ALU, load tracking, LSU response, hazard query and register-file write port.
// The stage connects through the slave modport; the upstream pipeline side uses master.
interface wb_stage_if;
    logic        alu_valid_i;
    logic        alu_ready_o;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        load_issue_i;
    logic        load_ready_o;
    logic [4:0]  load_rd_i;
    logic [2:0]  load_funct3_i;
    logic [1:0]  load_off_i;
    logic        lsu_rvalid_i;
    logic [31:0] lsu_rdata_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [4:0]  rd_chk_i;
    logic        hazard_o;
    logic [31:0] rf_rdata1_i;
    logic [31:0] rf_rdata2_i;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic        write_en_o;
    logic [4:0]  write_addr_o;
    logic [31:0] write_data_o;
    logic        unexp_rsp_o;

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output load_issue_i, load_rd_i, load_funct3_i, load_off_i,
        output lsu_rvalid_i, lsu_rdata_i,
        output rs1_i, rs2_i, rd_chk_i, rf_rdata1_i, rf_rdata2_i,
        input  alu_ready_o, load_ready_o, hazard_o, rs1_data_o, rs2_data_o,
        input  write_en_o, write_addr_o, write_data_o, unexp_rsp_o
    );

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  load_issue_i, load_rd_i, load_funct3_i, load_off_i,
        input  lsu_rvalid_i, lsu_rdata_i,
        input  rs1_i, rs2_i, rd_chk_i, rf_rdata1_i, rf_rdata2_i,
        output alu_ready_o, load_ready_o, hazard_o, rs1_data_o, rs2_data_o,
        output write_en_o, write_addr_o, write_data_o, unexp_rsp_o
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: merges ALU results and in-order load responses onto the register-file write port.
// Define WB_FORWARD_EN to bypass the in-flight write to operands and drop it from hazard detection.
module wb_stage #(
    parameter int unsigned LOAD_DEPTH = 4
) (
    input logic        clk,
    input logic        rst_n,
    wb_stage_if.slave  bus
);
    localparam int unsigned PW = $clog2(LOAD_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [4:0]    fifo_rd  [LOAD_DEPTH];
    logic [2:0]    fifo_f3  [LOAD_DEPTH];
    logic [1:0]    fifo_off [LOAD_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          skid_valid;
    logic [4:0]    skid_rd;
    logic [31:0]   skid_data;

    logic          wr_en_q;
    logic [4:0]    wr_addr_q;
    logic [31:0]   wr_data_q;
    logic          unexp_q;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          alu_acc;

    logic          win_en;
    logic [4:0]    win_rd;
    logic [31:0]   win_data;
    logic          skid_load;
    logic          skid_clear;
    logic [31:0]   busy;

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*off +: 8];
        h = word[16*off[1] +: 16];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'd0, b};
            3'd5:    return {16'd0, h};
            default: return word;
        endcase
    endfunction

    assign full    = (count == CW'(LOAD_DEPTH));
    assign empty   = (count == '0);
    assign push    = bus.load_issue_i && !full;
    assign pop     = bus.lsu_rvalid_i && !empty;
    assign alu_acc = bus.alu_valid_i && !skid_valid;

    // A load response always owns the port; an ALU result accepted alongside it parks in the skid.
    always_comb begin
        win_en     = 1'b0;
        win_rd     = '0;
        win_data   = '0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (pop) begin
            win_en    = 1'b1;
            win_rd    = fifo_rd[rd_ptr];
            win_data  = extend(fifo_f3[rd_ptr], fifo_off[rd_ptr], bus.lsu_rdata_i);
            skid_load = alu_acc;
        end else if (skid_valid) begin
            win_en     = 1'b1;
            win_rd     = skid_rd;
            win_data   = skid_data;
            skid_clear = 1'b1;
        end else if (alu_acc) begin
            win_en   = 1'b1;
            win_rd   = bus.alu_rd_i;
            win_data = bus.alu_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]  <= bus.load_rd_i;
            fifo_f3[wr_ptr]  <= bus.load_funct3_i;
            fifo_off[wr_ptr] <= bus.load_off_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            skid_valid <= 1'b0;
            skid_rd    <= '0;
            skid_data  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            unexp_q    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            if (bus.lsu_rvalid_i && empty) unexp_q <= 1'b1;

            if (skid_load) begin
                skid_valid <= 1'b1;
                skid_rd    <= bus.alu_rd_i;
                skid_data  <= bus.alu_data_i;
            end else if (skid_clear) begin
                skid_valid <= 1'b0;
            end

            wr_en_q <= win_en && (win_rd != '0);
            if (win_en) begin
                wr_addr_q <= win_rd;
                wr_data_q <= win_data;
            end
        end
    end

    // One bit per architectural register with a write still pending; x0 is never busy.
    always_comb begin
        busy = '0;
        for (int unsigned k = 0; k < LOAD_DEPTH; k++) begin
            if (CW'(k) < count) busy[fifo_rd[rd_ptr + PW'(k)]] = 1'b1;
        end
        if (skid_valid) busy[skid_rd] = 1'b1;
`ifndef WB_FORWARD_EN
        if (wr_en_q) busy[wr_addr_q] = 1'b1;
`endif
        busy[0] = 1'b0;
    end

    assign bus.hazard_o     = busy[bus.rs1_i] || busy[bus.rs2_i] || busy[bus.rd_chk_i];
    assign bus.alu_ready_o  = !skid_valid;
    assign bus.load_ready_o = !full;
    assign bus.write_en_o   = wr_en_q;
    assign bus.write_addr_o = wr_addr_q;
    assign bus.write_data_o = wr_data_q;
    assign bus.unexp_rsp_o  = unexp_q;

`ifdef WB_FORWARD_EN
    assign bus.rs1_data_o = (wr_en_q && wr_addr_q == bus.rs1_i && bus.rs1_i != '0)
                            ? wr_data_q : bus.rf_rdata1_i;
    assign bus.rs2_data_o = (wr_en_q && wr_addr_q == bus.rs2_i && bus.rs2_i != '0)
                            ? wr_data_q : bus.rf_rdata2_i;
`else
    assign bus.rs1_data_o = bus.rf_rdata1_i;
    assign bus.rs2_data_o = bus.rf_rdata2_i;
`endif
endmodule
